cdb_arbiter: RTL and testbench

- Receiving end of the CDB handshake that every execution unit drives (cdb_valid_o / cdb_data_o out, cdb_ready_i in).
- Collects result requests from EU_N execution units and grants one per cycle with round-robin arbitration.
- Registers the granted result and broadcasts it on the common data bus to the ROB and all reservation stations.
- Sits in expipe, between the execution-unit wrappers and the ROB.

---
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among EU_N execution units, one registered broadcast per cycle.
// Define CDB_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] res_value;
        logic        except_raised;
        logic [4:0]  except_code;
    } cdb_data_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int EU_N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic [EU_N-1:0]      eu_valid_i,
    output logic [EU_N-1:0]      eu_ready_o,
    input  cdb_data_t [EU_N-1:0] eu_data_i,
    input  logic                 rob_ready_i,
    output logic                 cdb_valid_o,
    output cdb_data_t            cdb_data_o
);
    localparam int PW = (EU_N > 1) ? $clog2(EU_N) : 1;

    logic          out_valid_q;
    logic          out_valid_d;
    cdb_data_t     out_data_q;
    cdb_data_t     out_data_d;
    logic [PW-1:0] prio;
    logic          can_load;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign prio = '0;
`else
    logic [PW-1:0] prio_q;
    logic [PW-1:0] prio_d;
    assign prio = prio_q;
`endif

    // Holding reset low also suppresses grants, so no EU sees a handshake mid-reset.
    assign can_load = rst_n_i && !flush_i && (!out_valid_q || rob_ready_i);

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < EU_N; i++) begin
            idx = int'(prio) + i;
            if (idx >= EU_N) begin
                idx = idx - EU_N;
            end
            if (can_load && !grant_valid && eu_valid_i[PW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < EU_N; gi++) begin : g_ready
        assign eu_ready_o[gi] = grant_valid && (grant_idx == PW'(gi));
    end

    // A new grant overwrites a result being consumed in the same cycle, so there is no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (grant_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = eu_data_i[grant_idx];
        end else if (rob_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        prio_d = prio_q;
        if (grant_valid) begin
            prio_d = (grant_idx == PW'(EU_N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            prio_q      <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign cdb_valid_o = out_valid_q;
    assign cdb_data_o  = out_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin, wrap, backpressure, flush, reset mid-stream.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [3:0]           eu_valid;
    logic [3:0]           eu_ready;
    cdb_data_t [3:0]      eu_data;
    logic                 rob_ready;
    logic                 cdb_valid;
    cdb_data_t            cdb_data;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.EU_N(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .eu_valid_i  (eu_valid),
        .eu_ready_o  (eu_ready),
        .eu_data_i   (eu_data),
        .rob_ready_i (rob_ready),
        .cdb_valid_o (cdb_valid),
        .cdb_data_o  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cdb_data_t mk(input int r);
        cdb_data_t d;
        d.rob_idx       = 6'(r);
        d.res_value     = 32'hC0DE_0000 | 32'(r);
        d.except_raised = 1'(r & 1);
        d.except_code   = 5'(r);
        return d;
    endfunction

    // Advance one edge and land 1 ns after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rob_ready = 1'b1; eu_valid = 4'b1111;
        for (int k = 0; k < 4; k++) eu_data[k] = mk(20 + k);
        tick(); tick();
        n_checks++;
        if (eu_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp %b", eu_ready, 4'b0000); end
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", cdb_valid); end
        n_checks++;
        if (cdb_data !== cdb_data_t'('0)) begin n_fail++; $display("FAIL reset_data got %h exp 0", cdb_data); end
        $display("reset: ready=%b valid=%b data=%h", eu_ready, cdb_valid, cdb_data);
        eu_valid = 4'b0000; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int exp_rob;
        eu_valid = 4'b0100; eu_data[2] = mk(5);
        #1;
        n_checks++;
        if (eu_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp %b", eu_ready, 4'b0100); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== mk(5)) begin
            n_fail++; $display("FAIL single_bcast got v=%b rob=%0d exp v=1 rob=5", cdb_valid, cdb_data.rob_idx);
        end
        $display("single: EU2 granted, bcast rob=%0d", cdb_data.rob_idx);
        // Pointer should now sit at 3: with EU0 and EU3 requesting, EU3 wins.
        eu_valid = 4'b1001; eu_data[0] = mk(1); eu_data[3] = mk(3);
        exp_rob = FIXED ? 1 : 3;
        #1;
        n_checks++;
        if (eu_ready !== (FIXED ? 4'b0001 : 4'b1000)) begin
            n_fail++; $display("FAIL single_prio_ready got %b exp %b", eu_ready, (FIXED ? 4'b0001 : 4'b1000));
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== mk(exp_rob)) begin
            n_fail++; $display("FAIL single_prio_bcast got v=%b rob=%0d exp v=1 rob=%0d", cdb_valid, cdb_data.rob_idx, exp_rob);
        end
        $display("single: follow-up bcast rob=%0d", cdb_data.rob_idx);
        eu_valid = 4'b0000;
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== mk(exp_rob)) begin
            n_fail++; $display("FAIL consume_idle got v=%b rob=%0d exp v=0 rob=%0d", cdb_valid, cdb_data.rob_idx, exp_rob);
        end
        $display("single: consumed, valid=%b", cdb_valid);
    endtask

    task automatic test_round_robin();
        int exp_k;
        for (int k = 0; k < 4; k++) eu_data[k] = mk(20 + k);
        eu_valid = 4'b1111; rob_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_k = FIXED ? 0 : (i % 4);
            #1;
            n_checks++;
            if (eu_ready !== 4'(1 << exp_k)) begin
                n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", i, eu_ready, 4'(1 << exp_k));
            end
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_data !== mk(20 + exp_k)) begin
                n_fail++; $display("FAIL rr_bcast[%0d] got v=%b rob=%0d exp v=1 rob=%0d", i, cdb_valid, cdb_data.rob_idx, 20 + exp_k);
            end
            $display("rr[%0d]: ready=%b bcast rob=%0d", i, eu_ready, cdb_data.rob_idx);
        end
        eu_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        eu_valid = 4'b0100;
        tick();
        eu_valid = 4'b0011;
        #1;
        n_checks++;
        if (eu_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0 got %b exp %b", eu_ready, 4'b0001); end
        tick();
        n_checks++;
        if (cdb_data !== mk(20)) begin n_fail++; $display("FAIL wrap_bcast0 got rob=%0d exp rob=20", cdb_data.rob_idx); end
        $display("wrap: first grant bcast rob=%0d", cdb_data.rob_idx);
        #1;
        n_checks++;
        if (eu_ready !== (FIXED ? 4'b0001 : 4'b0010)) begin
            n_fail++; $display("FAIL wrap_ready1 got %b exp %b", eu_ready, (FIXED ? 4'b0001 : 4'b0010));
        end
        tick();
        n_checks++;
        if (cdb_data !== mk(FIXED ? 20 : 21)) begin
            n_fail++; $display("FAIL wrap_bcast1 got rob=%0d exp rob=%0d", cdb_data.rob_idx, FIXED ? 20 : 21);
        end
        $display("wrap: second grant bcast rob=%0d", cdb_data.rob_idx);
        eu_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        eu_data[0] = mk(7); eu_valid = 4'b0001;
        tick();
        rob_ready = 1'b0; eu_valid = 4'b0010; eu_data[1] = mk(9);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (eu_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp %b", i, eu_ready, 4'b0000); end
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_data !== mk(7)) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b rob=%0d exp v=1 rob=7", i, cdb_valid, cdb_data.rob_idx);
            end
            $display("bp[%0d]: stalled, bcast rob=%0d", i, cdb_data.rob_idx);
        end
        rob_ready = 1'b1;
        #1;
        n_checks++;
        if (eu_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got %b exp %b", eu_ready, 4'b0010); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== mk(9)) begin
            n_fail++; $display("FAIL bp_release_bcast got v=%b rob=%0d exp v=1 rob=9", cdb_valid, cdb_data.rob_idx);
        end
        $display("bp: released, bcast rob=%0d", cdb_data.rob_idx);
        eu_valid = 4'b0000;
        tick();
    endtask

    task automatic test_flush();
        eu_data[3] = mk(11); eu_valid = 4'b1000;
        tick();
        flush = 1'b1;
        #1;
        n_checks++;
        if (eu_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got %b exp %b", eu_ready, 4'b0000); end
        tick();
        flush = 1'b0;
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", cdb_valid); end
        $display("flush: bcast dropped, valid=%b", cdb_valid);
        #1;
        n_checks++;
        if (eu_ready !== 4'b1000) begin n_fail++; $display("FAIL post_flush_ready got %b exp %b", eu_ready, 4'b1000); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== mk(11)) begin
            n_fail++; $display("FAIL post_flush_bcast got v=%b rob=%0d exp v=1 rob=11", cdb_valid, cdb_data.rob_idx);
        end
        $display("flush: EU3 regranted, bcast rob=%0d", cdb_data.rob_idx);
        eu_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back_reset();
        for (int k = 0; k < 4; k++) eu_data[k] = mk(20 + k);
        eu_valid = 4'b1111;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (eu_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready got %b exp %b", eu_ready, 4'b0000); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_data !== cdb_data_t'('0)) begin
            n_fail++; $display("FAIL rst_mid_out got v=%b data=%h exp v=0 data=0", cdb_valid, cdb_data);
        end
        $display("rst_mid: valid=%b data=%h", cdb_valid, cdb_data);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (eu_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_after_ready got %b exp %b", eu_ready, 4'b0001); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_data !== mk(20)) begin
            n_fail++; $display("FAIL rst_after_bcast got v=%b rob=%0d exp v=1 rob=20", cdb_valid, cdb_data.rob_idx);
        end
        $display("rst_mid: EU0 first after release, bcast rob=%0d", cdb_data.rob_idx);
        eu_valid = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; rob_ready = 1'b1; eu_valid = 4'b0000;
        for (int k = 0; k < 4; k++) eu_data[k] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_flush();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
